// File: rtl/fifo_arb_pkg.sv
// Shared types and constant helpers for the FIFO write-port arbiter.
// No logic; imported by the arbiter top and picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [IW-1:0] o_idx
);

    // Doubled vector lets the scan run linearly from ptr without a modulo in the loop.
    logic [2*N-2:0] w_dbl;
    logic           w_found;

    assign w_dbl = {i_valid[N-2:0], i_valid};
    assign o_any = |i_valid;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_dbl[int'(i_ptr) + k]) begin
                w_found = 1'b1;
                o_idx   = (int'(i_ptr) + k >= N) ? IW'(int'(i_ptr) + k - N)
                                                 : IW'(int'(i_ptr) + k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ producers in bursts.
// Latency: 1 idle arbitration cycle per grant, then one word per cycle combinationally.
// Backpressure: w_full drops the owner's ready and w_en; the grant is held while full.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                w_clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                w_full,
    output logic                w_en,
    output logic [DW-1:0]       w_data,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int IDW = clog2(N_REQ);
    localparam int BW  = clog2(BURST_LEN) + 1;
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_REQ - 1);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_own;
    logic [IDW-1:0]     w_pick;
    logic               w_any;
    logic [BW-1:0]      r_beat;
    logic [N_REQ-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_own_vld;
    logic               w_xfer;
    logic               w_rel;

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_idx   (w_pick)
    );

    assign w_own_vld = req_valid[r_own];
    assign w_xfer    = (r_state == BURST) && w_own_vld && !w_full;
    // Release on the last beat of a burst, or as soon as the owner runs dry.
    assign w_rel     = (r_state == BURST) &&
                       ((w_xfer && (r_beat == LAST_BEAT)) || !w_own_vld);

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = BURST;
            BURST:   if (w_rel) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        w_en      = 1'b0;
        if (r_state == BURST) begin
            req_ready[r_own] = ~w_full;
            w_en             = w_own_vld & ~w_full;
        end
    end

    assign w_data    = req_data[r_own*DW +: DW];
    assign gnt       = r_gnt;
    assign busy      = (r_state == BURST);
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_own       <= '0;
            r_beat      <= '0;
            r_gnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_any) begin
                r_own  <= w_pick;
                r_gnt  <= N_REQ'(1) << w_pick;
                r_beat <= '0;
            end
            if (w_xfer) begin
                r_beat <= r_beat + 1'b1;
            end
            if ((r_state == BURST) && w_own_vld && w_full && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // Owner moves to the back of the queue so a waiting rival wins next IDLE.
            if (w_rel) begin
                r_ptr <= (r_own == LAST_IDX) ? '0 : r_own + 1'b1;
                r_gnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: producer queues drive the DUT, expected FIFO
// words are queued at load time and checked in order on every w_en.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic            w_clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            w_full;
    logic            w_en;
    logic [DW-1:0]   w_data;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [CW-1:0]   stall_cnt;

    logic [DW-1:0]   src_q [N][$];
    logic [DW-1:0]   exp_q [$];
    int              n_chk;
    int              n_pass;
    int              wr_cnt;

    fifo_wr_arb #(
        .N_REQ     (N),
        .DW        (DW),
        .BURST_LEN (4),
        .CNT_W     (CW)
    ) dut (
        .w_clk     (w_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w_full    (w_full),
        .w_en      (w_en),
        .w_data    (w_data),
        .gnt       (gnt),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic load(input int r, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[r].push_back(DW'(base + k));
            exp_q.push_back(DW'(base + k));
        end
    endtask

    // Observe at negedge, advance producers just after posedge.
    task automatic tick();
        logic [N-1:0] xf;
        @(negedge w_clk);
        if (w_en) begin
            wr_cnt++;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("w_data", 32'(w_data), 32'(exp_q.pop_front()));
        end
        xf = req_valid & req_ready;
        @(posedge w_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xf[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        for (int k = 0; k < max && exp_q.size() != 0; k++) tick();
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        w_full = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge w_clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [N-1:0] prev_g;
        logic [N-1:0] exp_g [5];
        int           ng;
        int           idle_run;
        int           wr0;

        n_chk     = 0;
        n_pass    = 0;
        wr_cnt    = 0;
        req_valid = '0;
        req_data  = '0;
        w_full    = 1'b0;
        rst_n     = 1'b1;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_wen", 32'(w_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // 1: single producer, 6 words split into 4 + 2 bursts
        load(0, 8'h10, 6);
        drive();
        #1;
        chk("t1_arb_gnt", 32'(gnt), 32'd0);
        chk("t1_arb_wen", 32'(w_en), 32'd0);
        tick();
        chk("t1_gnt", 32'(gnt), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            chk("t1_burst_wen", 32'(w_en), 32'd1);
            tick();
        end
        chk("t1_gap_busy", 32'(busy), 32'd0);
        chk("t1_gap_wen", 32'(w_en), 32'd0);
        tick();
        chk("t1_regrant", 32'(gnt), 32'b0001);
        drain("t1", 10);
        chk("t1_release", 32'(busy), 32'd0);

        // 2: all four contend; expect 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        load(0, 8'h00, 4);
        load(1, 8'h10, 4);
        load(2, 8'h20, 4);
        load(3, 8'h30, 4);
        load(0, 8'h04, 4);
        drive();
        #1;
        exp_g    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev_g   = '0;
        ng       = 0;
        idle_run = 0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            tick();
            chk("t2_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (gnt != '0 && prev_g == '0) begin
                if (ng < 5) chk("t2_order", 32'(gnt), 32'(exp_g[ng]));
                if (ng > 0) chk("t2_gap", 32'(idle_run), 32'd1);
                ng++;
                idle_run = 0;
            end else if (gnt == '0) begin
                idle_run++;
            end
            prev_g = gnt;
        end
        chk("t2_ngrants", 32'(ng), 32'd5);
        drain("t2", 5);

        // 3: w_full for 3 cycles after beat 1; beat holds, burst still ends after 4 words
        do_reset();
        load(0, 8'h30, 5);
        drive();
        #1;
        tick();
        tick();
        w_full = 1'b1;
        #1;
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        chk("t3_full_wen", 32'(w_en), 32'd0);
        repeat (3) begin
            tick();
            chk("t3_stall_wen", 32'(w_en), 32'd0);
        end
        w_full = 1'b0;
        #1;
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t3_gnt_held", 32'(gnt), 32'b0001);
        chk("t3_resume_wen", 32'(w_en), 32'd1);
        repeat (3) tick();
        chk("t3_end_busy", 32'(busy), 32'd0);
        chk("t3_end_gnt", 32'(gnt), 32'd0);
        drain("t3", 10);

        // 4: req2 runs dry after 2 beats; ptr=3 means req3 beats a waiting req0
        do_reset();
        load(2, 8'h20, 2);
        drive();
        #1;
        tick();
        chk("t4_gnt2", 32'(gnt), 32'b0100);
        load(3, 8'h40, 2);
        load(0, 8'h50, 1);
        drive();
        #1;
        chk("t4_ready_own", 32'(req_ready), 32'b0100);
        tick();
        tick();
        chk("t4_dry_busy", 32'(busy), 32'd1);
        chk("t4_dry_wen", 32'(w_en), 32'd0);
        tick();
        chk("t4_rel_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t4_gnt3", 32'(gnt), 32'b1000);
        drain("t4", 12);

        // 5: async reset mid-burst
        do_reset();
        load(1, 8'h60, 4);
        drive();
        #1;
        tick();
        chk("t5_gnt1", 32'(gnt), 32'b0010);
        tick();
        w_full = 1'b1;
        #1;
        tick();
        chk("t5_pre_stall", 32'(stall_cnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_wen", 32'(w_en), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_stall", 32'(stall_cnt), 32'd0);
        tick();
        rst_n  = 1'b1;
        w_full = 1'b0;
        exp_q.delete();
        load(0, 8'h70, 1);
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h63);
        drive();
        #1;
        chk("t5_post_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t5_req0_first", 32'(gnt), 32'b0001);
        drain("t5", 12);

        // 6: long w_full saturates the 4-bit stall counter without releasing
        do_reset();
        load(0, 8'h80, 1);
        w_full = 1'b1;
        drive();
        #1;
        tick();
        chk("t6_gnt", 32'(gnt), 32'b0001);
        wr0 = wr_cnt;
        repeat (20) tick();
        chk("t6_sat", 32'(stall_cnt), 32'd15);
        chk("t6_gnt_held", 32'(gnt), 32'b0001);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_no_write", 32'(wr_cnt - wr0), 32'd0);
        w_full = 1'b0;
        #1;
        drain("t6", 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
